// File: rtl/fixedpoint_accumulator.sv
// -----------------------------------------------------------------------------
// fixedpoint_accumulator
//
// Sums N_ACC signed Q(WI.WF) samples from the fixed-point adder into a wider
// Q(WIA.WF) accumulator, then presents the frame total with a sticky overflow
// flag. The radix point is shared, so samples are only sign-extended.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame abort (drops any sample offered alongside it)
//   in_valid   input sample valid
//   in_ready   stage can accept a sample (high only in ACC)
//   in_data    signed Q(WI.WF) sample
//   in_ovf     upstream overflow flag for this sample
//   out_valid  frame total valid (high only in HOLD)
//   out_ready  consumer accepts the total
//   out_data   signed Q(WIA.WF) accumulator (frame total while out_valid=1)
//   out_ovf    sticky overflow for the frame
// -----------------------------------------------------------------------------
module fixedpoint_accumulator #(
    parameter int WI    = 5,
    parameter int WF    = 4,
    parameter int WIA   = 8,
    parameter int N_ACC = 4,
    parameter int SAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI+WF-1:0]     in_data,
    input  logic                 in_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIA+WF-1:0]    out_data,
    output logic                 out_ovf
);

    localparam int W_IN  = WI + WF;
    localparam int W_ACC = WIA + WF;
    localparam int CW    = $clog2(N_ACC + 1);

    localparam logic [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [W_ACC-1:0]   acc_q,   acc_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    // One guard bit above the accumulator width makes overflow detection a
    // simple compare of the two top bits of the sum.
    logic signed [W_ACC:0] acc_ext;
    logic signed [W_ACC:0] smp_ext;
    logic signed [W_ACC:0] sum;
    logic                  sum_ovf;
    logic                  last_smp;

    assign acc_ext  = {acc_q[W_ACC-1], acc_q};
    assign smp_ext  = (W_ACC+1)'($signed(in_data[W_IN-1:0]));
    assign sum      = acc_ext + smp_ext;
    assign sum_ovf  = sum[W_ACC] ^ sum[W_ACC-1];
    assign last_smp = (cnt_q == CW'(N_ACC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clr) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        // Saturation is not terminal: later samples keep
                        // accumulating from the clamped value.
                        if (sum_ovf && (SAT != 0)) begin
                            acc_d = sum[W_ACC] ? ACC_MIN : ACC_MAX;
                        end else begin
                            acc_d = sum[W_ACC-1:0];
                        end
                        ovf_d = ovf_q | sum_ovf | in_ovf;
                        if (last_smp) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register, so in_ready
    // never depends combinationally on out_ready.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fixedpoint_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fixedpoint_accumulator
//
// Four instances share one input stream:
//   u0 default, u1 WIA=6 SAT=1, u2 WIA=6 SAT=0, u3 N_ACC=1.
// Directed frame vectors come from a table; multi-cycle corner cases are
// hand-written; a random phase compares every instance against an
// arithmetic model of the accumulator (integer sums, clamp or modulo wrap).
// -----------------------------------------------------------------------------
module tb_fixedpoint_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        in_ovf;
    logic        out_ready;
    logic [3:0]  in_ready_v;
    logic [3:0]  out_valid_v;
    logic [3:0]  out_ovf_v;
    logic [11:0] od0;
    logic [9:0]  od1;
    logic [9:0]  od2;
    logic [11:0] od3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixedpoint_accumulator #(.WI(5), .WF(4), .WIA(8), .N_ACC(4), .SAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .in_ovf(in_ovf), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(od0), .out_ovf(out_ovf_v[0]));
    fixedpoint_accumulator #(.WI(5), .WF(4), .WIA(6), .N_ACC(4), .SAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .in_ovf(in_ovf), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(od1), .out_ovf(out_ovf_v[1]));
    fixedpoint_accumulator #(.WI(5), .WF(4), .WIA(6), .N_ACC(4), .SAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .in_ovf(in_ovf), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(od2), .out_ovf(out_ovf_v[2]));
    fixedpoint_accumulator #(.WI(5), .WF(4), .WIA(8), .N_ACC(1), .SAT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .in_data(in_data), .in_ovf(in_ovf), .out_valid(out_valid_v[3]), .out_ready(out_ready),
        .out_data(od3), .out_ovf(out_ovf_v[3]));

    // ---------------- reference model ----------------
    localparam int NACC[4] = '{4, 4, 4, 1};
    localparam int WACC[4] = '{12, 10, 10, 12};
    localparam int SATP[4] = '{1, 1, 0, 1};

    typedef struct {
        longint acc;   // signed running total
        bit     ovf;
        int     cnt;
        bit     hold;  // frame complete, waiting for the consumer
    } mstate_t;

    mstate_t m[4];

    function automatic mstate_t mstep(mstate_t c, int i, logic iv, logic [8:0] id,
                                      logic io, logic orr, logic cl);
        mstate_t n;
        longint  s, lo, hi, span, r;
        n = c;
        if (cl) begin
            n.acc = 0; n.ovf = 0; n.cnt = 0; n.hold = 0;
        end else if (!c.hold) begin
            if (iv) begin
                lo   = -(longint'(1) <<< (WACC[i] - 1));
                hi   = (longint'(1) <<< (WACC[i] - 1)) - 1;
                span = longint'(1) <<< WACC[i];
                s    = c.acc + longint'($signed(id));
                if (s > hi || s < lo) begin
                    n.ovf = 1;
                    if (SATP[i] != 0) begin
                        n.acc = (s > hi) ? hi : lo;
                    end else begin
                        r = (s - lo) % span;
                        if (r < 0) r = r + span;
                        n.acc = r + lo;
                    end
                end else begin
                    n.acc = s;
                end
                if (io) n.ovf = 1;
                n.cnt = c.cnt + 1;
                if (n.cnt == NACC[i]) begin
                    n.cnt  = 0;
                    n.hold = 1;
                end
            end
        end else if (orr) begin
            n.acc = 0; n.ovf = 0; n.hold = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m[i] <= '{0, 0, 0, 0};
        end else begin
            for (int i = 0; i < 4; i++)
                m[i] <= mstep(m[i], i, in_valid, in_data, in_ovf, out_ready, clr);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [63:0] dut_data(int i);
        case (i)
            0:       return {52'd0, od0};
            1:       return {54'd0, od1};
            2:       return {54'd0, od2};
            default: return {52'd0, od3};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [8:0] d, input logic o);
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = o;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_ovf   = 1'b0;
    endtask

    // ---------------- directed frame table ----------------
    typedef struct {
        logic [3:0][8:0] d;     // d[3] is applied first
        logic [3:0]      ovfm;  // in_ovf per sample, same ordering
        logic [11:0]     e0;  logic e0o;
        logic [9:0]      e1;  logic e1o;
        logic [9:0]      e2;  logic e2o;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{d: {9'h018, 9'h018, 9'h018, 9'h018}, ovfm: 4'b0000,
                    e0: 12'h060, e0o: 1'b0, e1: 10'h060, e1o: 1'b0, e2: 10'h060, e2o: 1'b0};
        vecs[1] = '{d: {9'h1F0, 9'h004, 9'h1D8, 9'h00C}, ovfm: 4'b0000,
                    e0: 12'hFD8, e0o: 1'b0, e1: 10'h3D8, e1o: 1'b0, e2: 10'h3D8, e2o: 1'b0};
        vecs[2] = '{d: {9'h010, 9'h010, 9'h010, 9'h010}, ovfm: 4'b0100,
                    e0: 12'h040, e0o: 1'b1, e1: 10'h040, e1o: 1'b1, e2: 10'h040, e2o: 1'b1};
        vecs[3] = '{d: {9'h010, 9'h010, 9'h010, 9'h010}, ovfm: 4'b0000,
                    e0: 12'h040, e0o: 1'b0, e1: 10'h040, e1o: 1'b0, e2: 10'h040, e2o: 1'b0};
        vecs[4] = '{d: {9'h0F0, 9'h0F0, 9'h0F0, 9'h0F0}, ovfm: 4'b0000,
                    e0: 12'h3C0, e0o: 1'b0, e1: 10'h1FF, e1o: 1'b1, e2: 10'h3C0, e2o: 1'b1};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid_v[0]}, 64'd0);
        check("reset_out_data",  dut_data(0), 64'd0);
        check("reset_out_ovf",   {63'd0, out_ovf_v[0]}, 64'd0);
        check("reset_in_ready",  {63'd0, in_ready_v[0]}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames with the consumer always ready.
        for (int v = 0; v < 5; v++) begin
            for (int k = 3; k >= 0; k--) send(vecs[v].d[k], vecs[v].ovfm[k]);
            check($sformatf("v%0d_valid", v), {60'd0, out_valid_v[3:0] & 4'b0111}, 64'h7);
            check($sformatf("v%0d_in_ready", v), {63'd0, in_ready_v[0]}, 64'd0);
            check($sformatf("v%0d_data_u0", v), dut_data(0), {52'd0, vecs[v].e0});
            check($sformatf("v%0d_ovf_u0", v),  {63'd0, out_ovf_v[0]}, {63'd0, vecs[v].e0o});
            check($sformatf("v%0d_data_u1", v), dut_data(1), {54'd0, vecs[v].e1});
            check($sformatf("v%0d_ovf_u1", v),  {63'd0, out_ovf_v[1]}, {63'd0, vecs[v].e1o});
            check($sformatf("v%0d_data_u2", v), dut_data(2), {54'd0, vecs[v].e2});
            check($sformatf("v%0d_ovf_u2", v),  {63'd0, out_ovf_v[2]}, {63'd0, vecs[v].e2o});
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_drop", v), {63'd0, out_valid_v[0]}, 64'd0);
        end

        // Back-pressure: total must stay frozen and no sample may be taken.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(9'h010, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 9'h0AA;
            @(posedge clk); #1;
            check($sformatf("bp%0d_valid", c),    {63'd0, out_valid_v[0]}, 64'd1);
            check($sformatf("bp%0d_data", c),     dut_data(0), 64'h040);
            check($sformatf("bp%0d_ovf", c),      {63'd0, out_ovf_v[0]}, 64'd0);
            check($sformatf("bp%0d_in_ready", c), {63'd0, in_ready_v[0]}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", {63'd0, in_ready_v[0]}, 64'd1);
        check("bp_release_valid",    {63'd0, out_valid_v[0]}, 64'd0);
        check("bp_release_data",     dut_data(0), 64'd0);

        // clr mid-frame; the sample offered with clr is dropped.
        send(9'h010, 1'b0);
        send(9'h010, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h0FF;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_data",  dut_data(0), 64'd0);
        check("clr_ready", {63'd0, in_ready_v[0]}, 64'd1);
        for (int k = 0; k < 4; k++) send(9'h008, 1'b0);
        check("clr_frame_valid", {63'd0, out_valid_v[0]}, 64'd1);
        check("clr_frame_data",  dut_data(0), 64'h020);
        check("clr_frame_ovf",   {63'd0, out_ovf_v[0]}, 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-frame acts without a clock edge.
        send(9'h010, 1'b1);
        send(9'h010, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_data", dut_data(0), 64'd0);
        check("arst_ovf",  {63'd0, out_ovf_v[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) send(9'h008, 1'b0);
        check("arst_frame_valid", {63'd0, out_valid_v[0]}, 64'd1);
        check("arst_frame_data",  dut_data(0), 64'h020);
        check("arst_frame_ovf",   {63'd0, out_ovf_v[0]}, 64'd0);
        @(posedge clk); #1;

        // Randomized traffic on all four instances against the model.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 9'($urandom);
            in_ovf    = ($urandom_range(7) == 0);
            out_ready = ($urandom_range(2) != 0);
            clr       = ($urandom_range(39) == 0);
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rnd%0d_u%0d_valid", c, i), {63'd0, out_valid_v[i]}, {63'd0, m[i].hold});
                check($sformatf("rnd%0d_u%0d_ready", c, i), {63'd0, in_ready_v[i]}, {63'd0, !m[i].hold});
                check($sformatf("rnd%0d_u%0d_data", c, i), dut_data(i),
                      64'(m[i].acc) & ((64'd1 << WACC[i]) - 64'd1));
                check($sformatf("rnd%0d_u%0d_ovf", c, i), {63'd0, out_ovf_v[i]}, {63'd0, m[i].ovf});
            end
        end
        clr      = 1'b0;
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
